uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
UART transmitter that serialises bytes onto a single output line as 8N1 frames, with optional parity. It sits on the output side of the tt_um_vbhatt_uart_led top and is the counterpart of the existing UART receive path, so the design can echo or report bytes to a host. Bytes enter over a valid/ready interface into a small FIFO. A baud-timed state machine drains the FIFO LSB-first.

Parameters:
CLK_HZ, 10_000_000, system clock frequency in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 2; elaboration error otherwise)
FIFO_DEPTH, 4, byte buffer depth; power of two, >= 2
PARITY_EN, 0, 1 = insert a parity bit between D7 and stop
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low, no new frame starts
tx_data  in  8  byte to send
tx_valid  in  1  tx_data is valid
tx_ready  out  1  FIFO can accept a byte; equals !full, registered
tx  out  1  serial line, idle high
busy  out  1  high while a frame is on the line or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): tx=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, FIFO pointers cleared. Reset mid-frame aborts the frame: tx returns high immediately and queued bytes are discarded.
- Handshake: a byte is accepted on a rising edge with tx_valid && tx_ready. tx_data is ignored otherwise. tx_ready does not depend on ena.
- Full FIFO: tx_ready=0 and no write occurs. A simultaneous push and pop is legal whenever tx_ready=1; in that case fifo_count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when FIFO non-empty && ena. The byte is popped into a shift register on the same edge and tx goes low from that edge.
- Latency: a byte accepted into an empty, idle FIFO at edge N with ena=1 drives tx low from edge N+1.
- Baud counter: each state holds tx for exactly CLKS_PER_BIT cycles. The counter reloads on every state or bit change.
- START: tx=0.
- DATA: 8 bits, LSB first. A bit index 0..7 advances on each baud expiry, with the shift register shifting right. After bit 7 the FSM goes to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR(data) XOR PARITY_ODD, computed on the popped byte.
- STOP: tx=1 for one bit time. On expiry: if the FIFO is non-empty && ena, go directly to START (pop on the same edge, no idle gap); otherwise go to IDLE.
- ena low mid-frame: the current frame completes normally; the next frame waits in IDLE until ena=1.
- Frame length: 10 bit times, or 11 with parity.
- busy = (state != IDLE) || (fifo_count != 0).
- All outputs are registered or a direct function of registers; no combinational path from inputs to tx.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count.

Decomposition:
- Package uart_pkg:
  - state enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - function parity_bit(byte, odd)
  - CLKS_PER_BIT width calculation
  - This package is shared with the receiver for frame constants.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count, same clk/rst_n. The top holds the FSM, baud counter and shift register.

Test Plan (CLK_HZ=1_000_000, BAUD=100_000, so 10 clocks per bit):
1. Reset asserted mid-idle, then released -> tx=1, tx_ready=1, busy=0, fifo_count=0. Reset asserted for 3 cycles during DATA -> tx goes 1 asynchronously and no further frame appears after release.
2. Single push 0xA5 with ena=1 -> tx low from the edge after accept for 10 clocks, then bits 1,0,1,0,0,1,0,1 at 10 clocks each, stop high 10 clocks. busy drops exactly 100 clocks after tx falls.
3. Hold tx_valid with bytes 0x01..0x06 back-to-back, FIFO_DEPTH=4 -> 5 bytes accepted (first popped immediately), then tx_ready=0. tx_ready rises on the edge the second byte is popped at the end of frame 1. All 6 frames are contiguous, with no idle cycle between stop and the next start.
4. PARITY_EN=1, send 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1. Frame is 110 clocks.
5. Drop ena during bit 3 of a frame with a second byte queued -> the frame completes, then tx stays high and fifo_count stays 1. Raising ena starts the second frame on the next edge.
6. Push and pop on the same edge while fifo_count=2 -> fifo_count stays 2 and byte order is preserved on the line.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART frame constants, TX state encoding and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int unsigned c_data_bits = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Guarded so an illegal ratio still yields a legal vector width for the error report.
  function automatic int unsigned baud_cnt_width(input int unsigned clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Synchronous byte FIFO; full/empty derived from the occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [7:0]                     wr_data,
  output logic [7:0]                     rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

  logic [7:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= c_ptr_w'(r_wr_ptr + 1'b1);
      if (w_do_pop)  r_rd_ptr <= c_ptr_w'(r_rd_ptr + 1'b1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= c_cnt_w'(r_count + 1'b1);
        2'b01:   r_count <= c_cnt_w'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : Buffered 8N1 UART transmitter with optional parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 10_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned    c_clks_per_bit = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned    c_cnt_w        = baud_cnt_width(c_clks_per_bit);
  localparam logic [c_cnt_w-1:0] c_baud_reload = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [2:0]     c_last_bit     = 3'(c_data_bits - 1);

  if (c_clks_per_bit < 2) begin : g_bad_baud
    $error("uart_tx_buffered: CLK_HZ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_t     r_state;
  uart_tx_state_t     w_state_nxt;
  logic [c_cnt_w-1:0] r_baud_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               r_parity;
  logic               w_par_nxt;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               w_pop;
  logic               w_expire;
  logic               w_can_start;
  logic [7:0]         w_rd_data;
  logic               w_full;
  logic               w_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_valid),
    .pop     (w_pop),
    .wr_data (tx_data),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  assign tx_ready    = !w_full;
  assign tx          = r_tx;
  assign busy        = (r_state != IDLE) || (fifo_count != '0);
  assign w_expire    = (r_baud_cnt == '0);
  assign w_can_start = !w_empty && ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= c_baud_reload;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_cnt_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_par_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_expire ? c_baud_reload : c_cnt_w'(r_baud_cnt - 1'b1);
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_parity;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = c_baud_reload;
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_shift_nxt = w_rd_data;
          w_par_nxt   = parity_bit(w_rd_data, PARITY_ODD);
        end
      end
      START: begin
        if (w_expire) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
        end
      end
      DATA: begin
        if (w_expire) begin
          if (r_bit_idx == c_last_bit) begin
            w_state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            w_idx_nxt   = r_bit_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end
      PARITY: begin
        if (w_expire) w_state_nxt = STOP;
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave no idle gap.
        if (w_expire) begin
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_shift_nxt = w_rd_data;
            w_par_nxt   = parity_bit(w_rd_data, PARITY_ODD);
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_par_nxt;
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Scoreboard bench for uart_tx_buffered at 10 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [2:0] fifo_count;

  logic [7:0] p_data = 8'h00;
  logic       pe_valid = 1'b0, po_valid = 1'b0;
  logic       pe_ready, pe_tx, pe_busy, po_ready, po_tx, po_busy;
  logic [2:0] pe_count, po_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4),
                     .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count));

  uart_tx_buffered #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4),
                     .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(p_data), .tx_valid(pe_valid),
    .tx_ready(pe_ready), .tx(pe_tx), .busy(pe_busy), .fifo_count(pe_count));

  uart_tx_buffered #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4),
                     .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(p_data), .tx_valid(po_valid),
    .tx_ready(po_ready), .tx(po_tx), .busy(po_busy), .fifo_count(po_count));

  // Every accepted byte becomes an expected frame on the main line.
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) sb.push_back(tx_data);
  end

  function automatic logic line_of(input int w);
    case (w)
      1:       return pe_tx;
      2:       return po_tx;
      default: return tx;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      1:       return pe_busy;
      2:       return po_busy;
      default: return busy;
    endcase
  endfunction

  task automatic wait_start(input int w, output int waited);
    waited = 0;
    while (line_of(w) !== 1'b0) begin
      if (waited >= 500) begin
        waited = -1;
        return;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  // Samples the middle of each bit; 'first' is the number of negedges to the start-bit middle.
  task automatic sample_frame(input int w, input int nbits, input int first,
                              output logic [10:0] bits);
    bits = '1;
    repeat (first) @(negedge clk);
    bits[0] = line_of(w);
    for (int i = 1; i < nbits; i++) begin
      repeat (10) @(negedge clk);
      bits[i] = line_of(w);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++;
    if ({pe_ready, po_ready, pe_tx, po_tx} !== 4'b1111 || pe_count !== 3'd0 || po_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_parity_insts: got ready=%b%b tx=%b%b cnt=%0d/%0d expected 11 11 0/0",
               pe_ready, po_ready, pe_tx, po_tx, pe_count, po_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({tx, tx_ready, busy} !== 3'b110) begin failures++; $display("FAIL idle_reset: got tx/ready/busy=%b%b%b expected 110", tx, tx_ready, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0] frame;
    logic [7:0] got, exp_b;
    int bad, first_bad;
    frame = {1'b1, 8'hA5, 1'b0};
    ena = 1'b1;
    @(negedge clk); tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_pre_start: got %b expected 1", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL single_latency: got %b expected 0", tx); end
    bad = 0; first_bad = -1; got = '0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      if (tx !== frame[i/10]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if ((i % 10 == 5) && (i / 10 >= 1) && (i / 10 <= 8)) got[i/10-1] = tx;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_waveform: got %0d wrong clocks (first at %0d) expected 0", bad, first_bad); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_99: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL single_busy_100: got busy=%b tx=%b expected 0 1", busy, tx); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL single_sb: got %h with no expected byte", got); end
    else begin
      exp_b = sb.pop_front();
      if (got !== exp_b) begin failures++; $display("FAIL single_data: got %h expected %h", got, exp_b); end
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin : drv
        int d, acc, guard;
        logic rdy;
        d = 1; acc = 0; guard = 0;
        tx_data = 8'd1; tx_valid = 1'b1;
        while (d <= 6 && guard < 3000) begin
          rdy = tx_ready;
          @(negedge clk);
          guard++;
          if (rdy) begin
            acc++;
            if (acc == 5) begin
              checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready: got %b expected 0", tx_ready); end
              checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL b2b_full_count: got %0d expected 4", fifo_count); end
            end
            d++;
            tx_data = 8'(d);
          end
        end
        tx_valid = 1'b0;
        checks++; if (acc != 6) begin failures++; $display("FAIL b2b_accepted: got %0d expected 6", acc); end
      end
      begin : mon
        logic [10:0] bits;
        logic [7:0] exp_b;
        int waited;
        for (int f = 0; f < 6; f++) begin
          wait_start(0, waited);
          checks++;
          if (waited < 0 || (f > 0 && waited != 0)) begin
            failures++; $display("FAIL b2b_gap frame %0d: got wait %0d expected 0", f, waited);
          end
          if (waited < 0) break;
          sample_frame(0, 10, 5, bits);
          checks++;
          if (sb.size() == 0) begin failures++; $display("FAIL b2b_sb frame %0d: got %h with no expected byte", f, bits[8:1]); end
          else begin
            exp_b = sb.pop_front();
            if ({bits[9], bits[8:1], bits[0]} !== {1'b1, exp_b, 1'b0}) begin
              failures++; $display("FAIL b2b_frame %0d: got %b expected %b", f, bits[9:0], {1'b1, exp_b, 1'b0});
            end
          end
          repeat (4) @(negedge clk);
          if (f == 0) begin
            checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_before_pop: got %b expected 0", tx_ready); end
          end
          @(negedge clk);
          if (f == 0) begin
            checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_at_pop: got %b expected 1", tx_ready); end
          end
        end
      end
    join
  endtask

  task automatic test_parity();
    logic [10:0] bits;
    logic exp_par;
    int waited;
    for (int w = 1; w <= 2; w++) begin
      @(negedge clk); p_data = 8'h07;
      if (w == 1) pe_valid = 1'b1; else po_valid = 1'b1;
      @(negedge clk); pe_valid = 1'b0; po_valid = 1'b0;
      wait_start(w, waited);
      checks++; if (waited < 0) begin failures++; $display("FAIL parity_start inst %0d: got timeout expected start bit", w); end
      if (waited >= 0) begin
        sample_frame(w, 11, 5, bits);
        exp_par = (^p_data) ^ (w == 2);
        checks++; if (bits[9] !== exp_par) begin failures++; $display("FAIL parity_bit inst %0d: got %b expected %b", w, bits[9], exp_par); end
        checks++;
        if ({bits[10], bits[8:1], bits[0]} !== {1'b1, 8'h07, 1'b0}) begin
          failures++; $display("FAIL parity_frame inst %0d: got %b expected 1_00000111_0 around parity", w, bits);
        end
        repeat (4) @(negedge clk);
        checks++; if (busy_of(w) !== 1'b1 || line_of(w) !== 1'b1) begin failures++; $display("FAIL parity_len_109 inst %0d: got busy=%b tx=%b expected 1 1", w, busy_of(w), line_of(w)); end
        @(negedge clk);
        checks++; if (busy_of(w) !== 1'b0) begin failures++; $display("FAIL parity_len_110 inst %0d: got busy=%b expected 0", w, busy_of(w)); end
      end
    end
  endtask

  task automatic test_ena();
    logic [10:0] bits;
    logic [7:0] exp_b;
    int bad_tx, bad_cnt;
    ena = 1'b1;
    @(negedge clk); tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'hC3;
    @(negedge clk); tx_valid = 1'b0;
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL ena_first_start: got %b expected 0", tx); end
    fork
      sample_frame(0, 10, 5, bits);
      begin repeat (43) @(negedge clk); ena = 1'b0; end
    join
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL ena_sb1: got %h with no expected byte", bits[8:1]); end
    else begin
      exp_b = sb.pop_front();
      if ({bits[9], bits[8:1], bits[0]} !== {1'b1, exp_b, 1'b0}) begin
        failures++; $display("FAIL ena_frame1: got %b expected %b", bits[9:0], {1'b1, exp_b, 1'b0});
      end
    end
    repeat (5) @(negedge clk);
    bad_tx = 0; bad_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx !== 1'b1) bad_tx++;
      if (fifo_count !== 3'd1) bad_cnt++;
      @(negedge clk);
    end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL ena_hold_tx: got %0d low clocks expected 0", bad_tx); end
    checks++; if (bad_cnt != 0) begin failures++; $display("FAIL ena_hold_count: got %0d wrong clocks expected 0", bad_cnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ena_hold_busy: got %b expected 1", busy); end
    ena = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL ena_resume: got %b expected 0", tx); end
    sample_frame(0, 10, 5, bits);
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL ena_sb2: got %h with no expected byte", bits[8:1]); end
    else begin
      exp_b = sb.pop_front();
      if ({bits[9], bits[8:1], bits[0]} !== {1'b1, exp_b, 1'b0}) begin
        failures++; $display("FAIL ena_frame2: got %b expected %b", bits[9:0], {1'b1, exp_b, 1'b0});
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_simul();
    logic [10:0] bits;
    logic [7:0] exp_b;
    int waited;
    ena = 1'b1;
    @(negedge clk); tx_data = 8'h81; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'h42;
    @(negedge clk); tx_data = 8'h24;
    @(negedge clk); tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_setup_count: got %0d expected 2", fifo_count); end
    sample_frame(0, 10, 4, bits);
    repeat (4) @(negedge clk);
    checks++; if (fifo_count !== 3'd2 || tx_ready !== 1'b1) begin failures++; $display("FAIL simul_pre_count: got %0d ready=%b expected 2 1", fifo_count, tx_ready); end
    tx_data = 8'h18; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_count: got %0d expected 2", fifo_count); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL simul_sb0: got %h with no expected byte", bits[8:1]); end
    else begin
      exp_b = sb.pop_front();
      if (bits[8:1] !== exp_b) begin failures++; $display("FAIL simul_frame0: got %h expected %h", bits[8:1], exp_b); end
    end
    for (int f = 1; f <= 3; f++) begin
      wait_start(0, waited);
      checks++; if (waited != 0) begin failures++; $display("FAIL simul_gap frame %0d: got wait %0d expected 0", f, waited); end
      if (waited < 0) break;
      sample_frame(0, 10, 5, bits);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL simul_sb frame %0d: got %h with no expected byte", f, bits[8:1]); end
      else begin
        exp_b = sb.pop_front();
        if ({bits[9], bits[8:1], bits[0]} !== {1'b1, exp_b, 1'b0}) begin
          failures++; $display("FAIL simul_frame %0d: got %b expected %b", f, bits[9:0], {1'b1, exp_b, 1'b0});
        end
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad_tx;
    ena = 1'b1;
    @(negedge clk); tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'h77;
    @(negedge clk); tx_data = 8'hE1;
    @(negedge clk); tx_valid = 1'b0;
    repeat (34) @(negedge clk);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL rst_mid_pre: got %b expected 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_async_tx: got %b expected 1", tx); end
    checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_async_state: got count=%0d busy=%b expected 0 0", fifo_count, busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    bad_tx = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
    end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL rst_mid_no_frame: got %0d low clocks expected 0", bad_tx); end
    checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rst_mid_after: got busy=%b count=%0d expected 0 0", busy, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_ena();
    test_simul();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
